// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation encodings,
// FSM state type, datapath width and a magnitude helper.
package mips_pkg;

    // Datapath width shared with the register file and the ALU.
    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_RUN    = 2'b01,
        MD_FINISH = 2'b10
    } md_state_e;

    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [MD_WIDTH-1:0] r;
        if (is_signed && v[MD_WIDTH-1]) begin
            r = {MD_WIDTH{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_md_datapath.sv
// Combinational single iteration of shift-add multiply / restoring divide,
// plus the final sign fix-up that produces HI/LO.
module mips_md_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div_i,
    input  logic               is_signed_i,
    input  logic               sign_a_i,
    input  logic               sign_b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   addend_i,
    output logic [2*WIDTH-1:0] acc_step_o,
    output logic [WIDTH-1:0]   hi_fix_o,
    output logic [WIDTH-1:0]   lo_fix_o
);

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     cand_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    // One iteration: multiply adds the addend when the low multiplier bit is set;
    // divide shifts the next dividend bit into the partial remainder.
    always_comb begin
        sum_s  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + (acc_i[0] ? {1'b0, addend_i} : {(WIDTH+1){1'b0}});
        cand_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        if (is_div_i) begin
            if (cand_s >= {1'b0, addend_i}) begin
                acc_step_o = {cand_s[WIDTH-1:0] - addend_i, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_o = {cand_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step_o = {sum_s, acc_i[WIDTH-1:1]};
        end
    end

    // Sign fix-up; a zero divisor forces an all-ones quotient while the remainder
    // naturally reproduces the dividend.
    always_comb begin
        prod_s = acc_i;
        quot_s = acc_i[WIDTH-1:0];
        rem_s  = acc_i[2*WIDTH-1:WIDTH];
        if (is_div_i) begin
            if (is_signed_i && (sign_a_i ^ sign_b_i)) begin
                quot_s = {WIDTH{1'b0}} - quot_s;
            end else begin
                quot_s = acc_i[WIDTH-1:0];
            end
            if (is_signed_i && sign_a_i) begin
                rem_s = {WIDTH{1'b0}} - rem_s;
            end else begin
                rem_s = acc_i[2*WIDTH-1:WIDTH];
            end
            if (addend_i == {WIDTH{1'b0}}) begin
                quot_s = {WIDTH{1'b1}};
            end else begin
                quot_s = quot_s;
            end
            hi_fix_o = rem_s;
            lo_fix_o = quot_s;
        end else begin
            if (is_signed_i && (sign_a_i ^ sign_b_i)) begin
                prod_s = {(2*WIDTH){1'b0}} - acc_i;
            end else begin
                prod_s = acc_i;
            end
            hi_fix_o = prod_s[2*WIDTH-1:WIDTH];
            lo_fix_o = prod_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mips_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and
// MTHI/MTLO write path; one result bit per cycle, busy/done handshake.
module mips_mult_div
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             signal_start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             signal_mthi,
    input  logic             signal_mtlo,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   addend_q, addend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0]   hi_fix_s;
    logic [WIDTH-1:0]   lo_fix_s;

    assign a_mag_s = md_abs(operand_a, op[0]);
    assign b_mag_s = md_abs(operand_b, op[0]);

    mips_md_datapath #(.WIDTH(WIDTH)) u_datapath (
        .is_div_i    (is_div_q),
        .is_signed_i (is_signed_q),
        .sign_a_i    (sign_a_q),
        .sign_b_i    (sign_b_q),
        .acc_i       (acc_q),
        .addend_i    (addend_q),
        .acc_step_o  (acc_step_s),
        .hi_fix_o    (hi_fix_s),
        .lo_fix_o    (lo_fix_s)
    );

    // Next-state and datapath register updates for the IDLE/RUN/FINISH sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        acc_d       = acc_q;
        addend_d    = addend_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (signal_start) begin
                    is_div_d    = op[1];
                    is_signed_d = op[0];
                    sign_a_d    = op[0] & operand_a[WIDTH-1];
                    sign_b_d    = op[0] & operand_b[WIDTH-1];
                    // Divide iterates over the dividend; multiply over the multiplier.
                    if (op[1]) begin
                        acc_d    = {{WIDTH{1'b0}}, a_mag_s};
                        addend_d = b_mag_s;
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, b_mag_s};
                        addend_d = a_mag_s;
                    end
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = MD_RUN;
                end else begin
                    if (signal_mthi) begin
                        hi_d = write_data;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (signal_mtlo) begin
                        lo_d = write_data;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            MD_RUN: begin
                acc_d = acc_step_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MD_FINISH;
                end else begin
                    state_d = MD_RUN;
                end
            end
            MD_FINISH: begin
                hi_d    = hi_fix_s;
                lo_d    = lo_fix_s;
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // State, operand and HI/LO registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MD_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            acc_q       <= {(2*WIDTH){1'b0}};
            addend_q    <= {WIDTH{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            acc_q       <= acc_d;
            addend_q    <= addend_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != MD_IDLE);
    assign done = done_q;

endmodule
